// File: rtl/control_unit.sv
// control_unit -- multi-cycle control FSM for the single-issue datapath.
//
// Takes the instruction register contents and the comparator flags from the
// datapath and drives every datapath control input.
// Instruction flow: IDLE -(start)-> BOOT -> FETCH -> DECODE -> EXEC -> PCUPD -> FETCH.
// The SYSTEM opcode halts the machine. Any unknown encoding traps to ILLEGAL.
// Both HALT and ILLEGAL are left only through reset.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start                level, sampled only in IDLE
//   instr[31:0]          IR contents (valid from DECODE onwards)
//   BEQ..BGEU            comparator flags for Ra vs Rb, sampled in EXEC
//   load_PC, load_IR     PC / IR load strobes
//   we, we_ram           register-file / data-RAM write strobes
//   decisor0..3          ALU-B source, ALU/store path, RF write source, PC source
//   somador_subtrator    ALU op, 0=add 1=sub
//   Ra, Rb, Rw           rs1, rs2, rd
//   entrada_mux_add_sub  sign-extended immediate
//   somador_PC           PC increment in words (1, or taken-branch offset)
//   PCres                constant RESET_PC
//   halted, illegal      sticky status
module control_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [31:0]     instr,
  input  logic            BEQ,
  input  logic            BNE,
  input  logic            BLT,
  input  logic            BGE,
  input  logic            BLTU,
  input  logic            BGEU,
  output logic            load_PC,
  output logic            load_IR,
  output logic            we,
  output logic            we_ram,
  output logic            decisor0,
  output logic            decisor1,
  output logic            decisor2,
  output logic            decisor3,
  output logic            somador_subtrator,
  output logic [4:0]      Ra,
  output logic [4:0]      Rb,
  output logic [4:0]      Rw,
  output logic [XLEN-1:0] entrada_mux_add_sub,
  output logic [XLEN-1:0] somador_PC,
  output logic [XLEN-1:0] PCres,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_PCUPD, S_HALT, S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t state;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Decoded fields. These are only meaningful while the IR is valid, i.e. in DECODE.
  logic            dec_ok, dec_halt, dec_we, dec_we_ram, dec_branch;
  logic            dec_d0, dec_d1, dec_d2, dec_sub;
  logic [XLEN-1:0] dec_imm;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    dec_ok     = 1'b1;
    dec_halt   = 1'b0;
    dec_we     = 1'b0;
    dec_we_ram = 1'b0;
    dec_branch = 1'b0;
    dec_d0     = 1'b0;
    dec_d1     = 1'b0;
    dec_d2     = 1'b0;
    dec_sub    = 1'b0;
    dec_imm    = '0;
    case (opcode)
      OP_LOAD: begin
        dec_ok  = (funct3 == 3'b011);
        dec_d0  = 1'b1;
        dec_d1  = 1'b1;
        dec_d2  = 1'b1;
        dec_we  = 1'b1;
        dec_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        dec_ok     = (funct3 == 3'b011);
        dec_d0     = 1'b1;
        dec_d2     = 1'b1;
        dec_we_ram = 1'b1;
        dec_imm    = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_IMM: begin
        // funct3 000 is ADDI; 010 is the in-house SUBI encoding.
        dec_ok  = (funct3 == 3'b000) || (funct3 == 3'b010);
        dec_d0  = 1'b1;
        dec_d1  = 1'b1;
        dec_sub = funct3[1];
        dec_we  = 1'b1;
        dec_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
      OP_REG: begin
        dec_ok  = (funct3 == 3'b000) &&
                  ((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
        dec_d1  = 1'b1;
        dec_sub = funct7[5];
        dec_we  = 1'b1;
      end
      OP_BRANCH: begin
        dec_ok     = (funct3 != 3'b010) && (funct3 != 3'b011);
        dec_d1     = 1'b1;
        dec_branch = 1'b1;
      end
      OP_SYSTEM: dec_halt = 1'b1;
      default:   dec_ok   = 1'b0;
    endcase
  end

  // Decode results captured on leaving DECODE. They stay stable through EXEC
  // and PCUPD even if the IR input changes afterwards.
  logic [4:0]      hold_ra, hold_rb, hold_rw;
  logic            hold_d0, hold_d1, hold_d2, hold_sub, hold_branch;
  logic [XLEN-1:0] hold_imm;
  logic [2:0]      hold_f3;
  logic [6:0]      hold_off;

  // In DECODE the fields come straight from the IR, which only becomes valid
  // in that cycle. From EXEC onwards the captured copy is used.
  always_comb begin
    if (state == S_DECODE) begin
      Ra                  = instr[19:15];
      Rb                  = instr[24:20];
      Rw                  = instr[11:7];
      decisor0            = dec_d0;
      decisor1            = dec_d1;
      decisor2            = dec_d2;
      somador_subtrator   = dec_sub;
      entrada_mux_add_sub = dec_imm;
    end else begin
      Ra                  = hold_ra;
      Rb                  = hold_rb;
      Rw                  = hold_rw;
      decisor0            = hold_d0;
      decisor1            = hold_d1;
      decisor2            = hold_d2;
      somador_subtrator   = hold_sub;
      entrada_mux_add_sub = hold_imm;
    end
  end

  logic taken;
  always_comb begin
    case (hold_f3)
      3'b000:  taken = BEQ;
      3'b001:  taken = BNE;
      3'b100:  taken = BLT;
      3'b101:  taken = BGE;
      3'b110:  taken = BLTU;
      3'b111:  taken = BGEU;
      default: taken = 1'b0;
    endcase
  end

  assign PCres = RESET_PC;

  // NOTE: all state and registered outputs use non-blocking assignments, so
  // every branch reads the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      load_PC     <= 1'b0;
      load_IR     <= 1'b0;
      we          <= 1'b0;
      we_ram      <= 1'b0;
      decisor3    <= 1'b0;
      somador_PC  <= XLEN'(1);
      halted      <= 1'b0;
      illegal     <= 1'b0;
      hold_ra     <= '0;
      hold_rb     <= '0;
      hold_rw     <= '0;
      hold_d0     <= 1'b0;
      hold_d1     <= 1'b0;
      hold_d2     <= 1'b0;
      hold_sub    <= 1'b0;
      hold_branch <= 1'b0;
      hold_imm    <= '0;
      hold_f3     <= '0;
      hold_off    <= '0;
    end else begin
      // Strobes default low, so each one lasts a single cycle.
      load_PC <= 1'b0;
      load_IR <= 1'b0;
      we      <= 1'b0;
      we_ram  <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state    <= S_BOOT;
          load_PC  <= 1'b1;
          decisor3 <= 1'b0;
        end
        S_BOOT: begin
          state      <= S_FETCH;
          load_IR    <= 1'b1;
          somador_PC <= XLEN'(1);
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          hold_ra     <= instr[19:15];
          hold_rb     <= instr[24:20];
          hold_rw     <= instr[11:7];
          hold_d0     <= dec_d0;
          hold_d1     <= dec_d1;
          hold_d2     <= dec_d2;
          hold_sub    <= dec_sub;
          hold_branch <= dec_branch;
          hold_imm    <= dec_imm;
          hold_f3     <= funct3;
          hold_off    <= instr[31:25];
          if (!dec_ok) begin
            state   <= S_ILLEGAL;
            illegal <= 1'b1;
            halted  <= 1'b1;
          end else if (dec_halt) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state  <= S_EXEC;
            // x0 is hard-wired to zero, so a write to it is dropped.
            we     <= dec_we && (instr[11:7] != 5'd0);
            we_ram <= dec_we_ram;
          end
        end
        S_EXEC: begin
          state    <= S_PCUPD;
          load_PC  <= 1'b1;
          decisor3 <= 1'b1;
          if (hold_branch && taken)
            somador_PC <= {{(XLEN-7){hold_off[6]}}, hold_off};
        end
        S_PCUPD: begin
          state      <= S_FETCH;
          load_IR    <= 1'b1;
          somador_PC <= XLEN'(1);
        end
        S_HALT, S_ILLEGAL: state <= state;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit. It drives instructions step by step and
// checks the control outputs in each FSM state against hand-computed values.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] instr;
  logic        BEQ, BNE, BLT, BGE, BLTU, BGEU;
  logic        load_PC, load_IR, we, we_ram;
  logic        decisor0, decisor1, decisor2, decisor3, somador_subtrator;
  logic [4:0]  Ra, Rb, Rw;
  logic [63:0] imm, somador_PC, PCres;
  logic        halted, illegal;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_we0, t_we1;
  logic seen;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
    .BEQ(BEQ), .BNE(BNE), .BLT(BLT), .BGE(BGE), .BLTU(BLTU), .BGEU(BGEU),
    .load_PC(load_PC), .load_IR(load_IR), .we(we), .we_ram(we_ram),
    .decisor0(decisor0), .decisor1(decisor1), .decisor2(decisor2),
    .decisor3(decisor3), .somador_subtrator(somador_subtrator),
    .Ra(Ra), .Rb(Rb), .Rw(Rw), .entrada_mux_add_sub(imm),
    .somador_PC(somador_PC), .PCres(PCres), .halted(halted), .illegal(illegal)
  );

  localparam logic [31:0] I_LD    = {12'd0, 5'd0, 3'b011, 5'd2, 7'b0000011};
  localparam logic [31:0] I_ADDI  = {12'd9, 5'd2, 3'b000, 5'd1, 7'b0010011};
  localparam logic [31:0] I_SUBI  = {12'd10, 5'd4, 3'b010, 5'd3, 7'b0010011};
  localparam logic [31:0] I_BNE   = {7'd3, 5'd4, 5'd2, 3'b001, 5'd0, 7'b1100011};
  localparam logic [31:0] I_BEQ   = {7'h7E, 5'd6, 5'd5, 3'b000, 5'd0, 7'b1100011};
  localparam logic [31:0] I_ADD5  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0110011};
  localparam logic [31:0] I_ADD0  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0, 7'b0110011};
  localparam logic [31:0] I_SUB7  = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd7, 7'b0110011};
  localparam logic [31:0] I_SD    = {7'h7F, 5'd5, 5'd6, 3'b011, 5'h1C, 7'b0100011};
  localparam logic [31:0] I_HALT  = 32'h0000_0073;
  localparam logic [31:0] I_BAD   = 32'h0000_007F;
  localparam logic [31:0] I_BADBR = {7'd0, 5'd1, 5'd1, 3'b010, 5'd0, 7'b1100011};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample half a cycle after the rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // From PCUPD (or BOOT) step through FETCH and into DECODE.
  task automatic to_decode(input logic [31:0] i);
    instr = i;
    tick();
    check("fetch_load_IR", load_IR, 1'b1);
    check("fetch_somador_PC", somador_PC, 64'd1);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; instr = '0;
    {BEQ, BNE, BLT, BGE, BLTU, BGEU} = '0;
    tick(); tick();

    // Values held during reset.
    check("rst_strobes", {load_PC, load_IR, we, we_ram}, 4'b0000);
    check("rst_decisors", {decisor0, decisor1, decisor2, decisor3, somador_subtrator}, 5'b0);
    check("rst_regs", {Ra, Rb, Rw}, 15'd0);
    check("rst_imm", imm, 64'd0);
    check("rst_somador_PC", somador_PC, 64'd1);
    check("rst_PCres", PCres, 64'd0);
    check("rst_status", {halted, illegal}, 2'b00);

    // Reset asserted in the middle of an ADD's EXEC cycle.
    rst_n = 1'b1; start = 1'b1; instr = I_ADD5;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("add_exec_we", we, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_strobes", {load_PC, load_IR, we, we_ram}, 4'b0000);
    check("abort_somador_PC", somador_PC, 64'd1);
    tick();
    check("abort_no_pcupd", {load_PC, load_IR, we, we_ram}, 4'b0000);

    // Boot followed by LD x2,0(x0).
    rst_n = 1'b1; start = 1'b1; instr = I_LD;
    tick();
    check("boot_load_PC", load_PC, 1'b1);
    check("boot_decisor3", decisor3, 1'b0);
    start = 1'b0;
    tick();
    check("ld_fetch_load_IR", load_IR, 1'b1);
    tick();
    check("ld_dec_regs", {Ra, Rw}, {5'd0, 5'd2});
    check("ld_dec_muxes", {decisor0, decisor1, decisor2}, 3'b111);
    check("ld_dec_no_strobe", {load_PC, load_IR, we, we_ram}, 4'b0000);
    tick();
    check("ld_exec_we", {we, we_ram}, 2'b10);
    check("ld_exec_Rw", Rw, 5'd2);
    check("ld_exec_muxes", {decisor0, decisor1, decisor2}, 3'b111);
    tick();
    check("ld_pcupd", {load_PC, decisor3, we}, 3'b110);
    check("ld_pcupd_somador_PC", somador_PC, 64'd1);

    // ADDI x1,x2,9 then SUBI x3,x4,10: one write each, four cycles apart.
    to_decode(I_ADDI);
    check("addi_dec", {imm, somador_subtrator, Ra, Rw}, {64'd9, 1'b0, 5'd2, 5'd1});
    tick();
    check("addi_exec_we", we, 1'b1);
    t_we0 = cyc;
    tick();
    check("addi_pcupd_we", we, 1'b0);
    to_decode(I_SUBI);
    check("subi_dec", {imm, somador_subtrator, Ra, Rw}, {64'd10, 1'b1, 5'd4, 5'd3});
    tick();
    check("subi_exec_we", we, 1'b1);
    t_we1 = cyc;
    check("we_spacing", 64'(t_we1 - t_we0), 64'd4);
    tick();

    // BNE x2,x4 with offset 3, taken and then not taken.
    BNE = 1'b1;
    to_decode(I_BNE);
    check("bne_dec", {decisor0, decisor1, Ra, Rb}, {1'b0, 1'b1, 5'd2, 5'd4});
    tick();
    check("bne_exec_no_write", {we, we_ram}, 2'b00);
    tick();
    check("bne_taken_pcupd", {load_PC, decisor3}, 2'b11);
    check("bne_taken_somador_PC", somador_PC, 64'd3);
    // The flag is high until EXEC, then drops; only the EXEC value counts.
    to_decode(I_BNE);
    tick();
    BNE = 1'b0; BEQ = 1'b1;
    tick();
    check("bne_not_taken_somador_PC", somador_PC, 64'd1);

    // BEQ with a negative offset wraps modulo 2^64.
    to_decode(I_BEQ);
    tick(); tick();
    check("beq_neg_somador_PC", somador_PC, 64'hFFFF_FFFF_FFFF_FFFE);
    BEQ = 1'b0;

    // ADD to x0 writes nothing.
    to_decode(I_ADD0);
    tick();
    check("add_x0_no_we", {we, we_ram}, 2'b00);
    tick();

    // SD with a negative S-type immediate.
    to_decode(I_SD);
    check("sd_dec_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check("sd_dec_muxes", {decisor0, decisor1, decisor2}, 3'b101);
    tick();
    check("sd_exec_we_ram", {we, we_ram}, 2'b01);
    tick();

    // SUB x7,x1,x2.
    to_decode(I_SUB7);
    check("sub_dec", {decisor0, decisor1, decisor2, somador_subtrator}, 4'b0101);
    tick();
    check("sub_exec_we", we, 1'b1);
    tick();

    // HALT: absorbing, start ignored, no strobes.
    to_decode(I_HALT);
    tick();
    check("halt_status", {halted, illegal}, 2'b10);
    start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | load_PC | load_IR | we | we_ram;
    end
    check("halt_quiet", seen, 1'b0);
    check("halt_sticky", halted, 1'b1);
    start = 1'b0;

    // Unknown opcode traps to ILLEGAL.
    rst_n = 1'b0;
    tick();
    check("rst_clears_halt", {halted, illegal}, 2'b00);
    rst_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    to_decode(I_BAD);
    tick();
    check("illegal_opcode", {halted, illegal}, 2'b11);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | load_PC | load_IR | we | we_ram;
    end
    check("illegal_quiet", seen, 1'b0);

    // Known branch opcode with a reserved funct3.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    to_decode(I_BADBR);
    tick();
    check("illegal_funct3", {halted, illegal}, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
